// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared constants and helpers for the round-robin stream multiplexer.
//   - MODE_FIXED / MODE_RR : arbitration mode selectors for the MODE parameter
//   - lock_state_e         : packet-lock FSM states
//   - clog2_min1()         : channel-index width, never narrower than 1 bit
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // $clog2(1) and $clog2(2) would give 0 and 1; an index needs at least one
    // bit, so small channel counts are clamped.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// ---------------------------------------------------------------------------
// rr_stream_mux_if
//   Bundle of the N producer-side streams and the single consumer-side stream
//   of rr_stream_mux.
//   Producer side : in_valid[N], in_ready[N], in_data[N*W], in_last[N]
//                   (channel i data lives at in_data[i*W +: W])
//   Consumer side : out_valid, out_ready, out_data[W], out_last, out_sel[SEL_W]
//   Modports:
//     master - the multiplexer itself (drives in_ready and the output stream)
//     slave  - the surrounding environment (producers + consumer)
// ---------------------------------------------------------------------------
interface rr_stream_mux_if
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) ();

    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_last;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [SEL_W-1:0] out_sel;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational N-way arbiter.
//   Inputs : req[N]          - per-channel request (in_valid)
//            ptr[SEL_W]      - round-robin search start (owned by the caller)
//            lock            - a packet is in flight, stick to lock_idx
//            lock_idx[SEL_W] - channel that owns the in-flight packet
//   Outputs: grant_idx       - selected channel
//            grant_vld       - the selected channel is actually requesting
//   MODE_FIXED: lowest requesting index wins.
//   MODE_RR   : first requesting index at or after ptr, wrapping N-1 -> 0.
//   While locked, only lock_idx can win; if it is idle, grant_vld is 0.
// ---------------------------------------------------------------------------
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock,
    input  logic [SEL_W-1:0] lock_idx,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [SEL_W-1:0] fp_idx;
    logic [SEL_W-1:0] rr_idx;

    // Scan from the top down so the last hit (lowest index) is the one kept.
    always_comb begin
        fp_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) fp_idx = SEL_W'(i);
        end
    end

    // Rotate the search start to ptr. ptr is only ever loaded with values
    // below N, but a non-power-of-two N leaves unreachable codes, so treat
    // any such code as 0 rather than indexing past the request vector.
    always_comb begin
        int   base;
        int   idx;
        logic found;
        rr_idx = '0;
        found  = 1'b0;
        base   = (int'(ptr) < N) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                rr_idx = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant_idx = (MODE == MODE_FIXED) ? fp_idx : rr_idx;
        grant_vld = |req;
        if (lock) begin
            grant_idx = lock_idx;
            grant_vld = req[lock_idx];
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux
//   N:1 valid/ready stream multiplexer with an internal arbiter and a single
//   registered output stage. Optionally holds the grant for a whole packet
//   (from the first beat until the beat carrying in_last).
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - rr_stream_mux_if.master: N input streams, one output stream
//             and out_sel (source channel of the current output beat)
//   Timing: a beat accepted on cycle t appears on the output at t+1; with
//   out_ready held high one beat moves per cycle. out_ready only reaches
//   in_ready combinationally, never out_valid/out_data.
// ---------------------------------------------------------------------------
module rr_stream_mux
    import mux_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MODE     = MODE_RR,
    parameter int PKT_LOCK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_stream_mux_if.master bus
);

    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0][W-1:0] ch_data;

    logic [SEL_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                load_en;
    logic                xfer;
    logic                xfer_last;
    logic [SEL_W-1:0]    nxt_ptr;

    lock_state_e         state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    lock_idx_q, lock_idx_d;

    logic                out_valid_q;
    logic                out_last_q;
    logic [W-1:0]        out_data_q;
    logic [SEL_W-1:0]    out_sel_q;

    assign ch_data = bus.in_data;

    rr_arbiter #(
        .N     (N),
        .MODE  (MODE),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr_q),
        .lock      (state_q == LOCKED),
        .lock_idx  (lock_idx_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // The output register can take a new beat when it is empty or being
    // drained this cycle.
    assign load_en   = !out_valid_q || bus.out_ready;
    assign xfer      = load_en && grant_vld;
    assign xfer_last = bus.in_last[grant_idx];
    assign nxt_ptr   = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);

    // One-hot ready toward the granted producer only; gating with grant_vld
    // keeps every ready low when nobody is requesting.
    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[grant_idx] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Packet-lock FSM and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // The pointer only moves when a beat ends arbitration: a single-beat
    // packet, the closing beat of a locked packet, or any beat when packet
    // locking is disabled. Opening a packet leaves it where it is.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            unique case (state_q)
                UNLOCKED: begin
                    if ((PKT_LOCK != 0) && !xfer_last) begin
                        state_d    = LOCKED;
                        lock_idx_d = grant_idx;
                    end else begin
                        ptr_d = nxt_ptr;
                    end
                end
                LOCKED: begin
                    // grant_idx equals lock_idx here, so nxt_ptr is past it.
                    if (xfer_last) begin
                        state_d = UNLOCKED;
                        ptr_d   = nxt_ptr;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ch_data[grant_idx];
                out_last_q  <= xfer_last;
                out_sel_q   <= grant_idx;
            end else begin
                // Drained with nothing to replace it (includes a locked
                // channel going idle mid-packet): emit a bubble, keep the
                // payload registers as they were.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule
